// File: rtl/perm_round_scheduler_if.sv
// Handshake bundle between the mode controller (master) and the Ascon
// permutation round scheduler (slave).
// Optional feature macro: PERM_ABORT_EN adds the 'abort' request line.
interface perm_round_scheduler_if #(
  parameter int CTR_W = 5
);
  logic             start;
  logic [CTR_W-1:0] rounds_in;
`ifdef PERM_ABORT_EN
  logic             abort;
`endif
  logic             ready;
  logic             busy;
  logic             load;
  logic             round_en;
  logic [CTR_W-1:0] ctr;
  logic [CTR_W-1:0] rounds;
  logic             done;
  logic             err;

  // Mode controller side: issues requests, observes strobes
  modport master (
`ifdef PERM_ABORT_EN
    output abort,
`endif
    output start, rounds_in,
    input  ready, busy, load, round_en, ctr, rounds, done, err
  );

  // Scheduler side: consumes requests, drives datapath strobes
  modport slave (
`ifdef PERM_ABORT_EN
    input  abort,
`endif
    input  start, rounds_in,
    output ready, busy, load, round_en, ctr, rounds, done, err
  );
endinterface

// File: rtl/perm_round_scheduler.sv
// Ascon permutation round scheduler.
// Accepts a 6/8/12-round permutation request, then walks the round datapath
// through LOAD, RUN (UNROLL rounds per clock) and a one-cycle DONE pulse.
// Illegal round counts run as 12 rounds and raise a one-cycle err with load.
// Optional feature macro: PERM_ABORT_EN adds an abort input that drops an
// in-flight permutation (LOAD or RUN) back to IDLE without a done pulse.
module perm_round_scheduler #(
  parameter int UNROLL = 1,
  parameter int CTR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  perm_round_scheduler_if.slave bus
);

  // Reject unsupported configurations at elaboration time.
  generate
    if ((UNROLL != 1) && (UNROLL != 2)) begin : g_bad_unroll
      $error("perm_round_scheduler: UNROLL must be 1 or 2");
    end
    if (CTR_W != 5) begin : g_bad_ctr_w
      $error("perm_round_scheduler: CTR_W must be 5");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [CTR_W-1:0] RND_6  = 5'd6;
  localparam logic [CTR_W-1:0] RND_8  = 5'd8;
  localparam logic [CTR_W-1:0] RND_12 = 5'd12;
  localparam logic [CTR_W-1:0] ONE    = 5'd1;
  localparam logic [CTR_W-1:0] STEP   = CTR_W'(UNROLL);

  state_t           state_r,    state_nx;
  logic [CTR_W-1:0] ctr_r,      ctr_nx;
  logic [CTR_W-1:0] rounds_r,   rounds_nx;
  logic             load_r,     load_nx;
  logic             round_en_r, round_en_nx;
  logic             done_r,     done_nx;
  logic             err_r,      err_nx;

  logic             abort_s;
  logic             legal_s;
  logic             last_s;

`ifdef PERM_ABORT_EN
  assign abort_s = bus.abort;
`else
  assign abort_s = 1'b0;
`endif

  // Only 6, 8 and 12 are valid Ascon round counts.
  assign legal_s = (bus.rounds_in == RND_6) || (bus.rounds_in == RND_8) ||
                   (bus.rounds_in == RND_12);
  // The final RUN cycle applies the round numbered 'rounds'.
  assign last_s  = ((ctr_r + STEP - ONE) == rounds_r);

  // Next-state and next-output decode; strobes default low, ctr/rounds hold.
  always_comb begin
    state_nx    = state_r;
    ctr_nx      = ctr_r;
    rounds_nx   = rounds_r;
    load_nx     = 1'b0;
    round_en_nx = 1'b0;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx  = ST_LOAD;
          load_nx   = 1'b1;
          ctr_nx    = ONE;
          rounds_nx = legal_s ? bus.rounds_in : RND_12;
          err_nx    = ~legal_s;
        end else begin
          state_nx  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort_s) begin
          state_nx    = ST_IDLE;
        end else begin
          state_nx    = ST_RUN;
          round_en_nx = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          state_nx    = ST_IDLE;
        end else if (last_s) begin
          state_nx    = ST_DONE;
          done_nx     = 1'b1;
        end else begin
          state_nx    = ST_RUN;
          round_en_nx = 1'b1;
          ctr_nx      = ctr_r + STEP;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset forces idle values immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ctr_r      <= 5'd0;
      rounds_r   <= RND_12;
      load_r     <= 1'b0;
      round_en_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nx;
      ctr_r      <= ctr_nx;
      rounds_r   <= rounds_nx;
      load_r     <= load_nx;
      round_en_r <= round_en_nx;
      done_r     <= done_nx;
      err_r      <= err_nx;
    end
  end

  assign bus.ready    = (state_r == ST_IDLE);
  assign bus.busy     = (state_r != ST_IDLE);
  assign bus.load     = load_r;
  assign bus.round_en = round_en_r;
  assign bus.ctr      = ctr_r;
  assign bus.rounds   = rounds_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_perm_round_scheduler.sv
// Bench for perm_round_scheduler: one UNROLL=1 and one UNROLL=2 instance
// share the same stimulus; each is compared every cycle against a timeline
// model (cycles since accept -> expected strobes and counter).
module tb_perm_round_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] rounds_in;
  logic       abort_v;

  always #5 clk = ~clk;

  perm_round_scheduler_if bus0 ();
  perm_round_scheduler_if bus1 ();

  assign bus0.start     = start;
  assign bus0.rounds_in = rounds_in;
  assign bus1.start     = start;
  assign bus1.rounds_in = rounds_in;
`ifdef PERM_ABORT_EN
  assign bus0.abort     = abort_v;
  assign bus1.abort     = abort_v;
`endif

  perm_round_scheduler #(.UNROLL(1), .CTR_W(5)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  perm_round_scheduler #(.UNROLL(2), .CTR_W(5)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Observed outputs gathered per instance
  logic       o_ready [2];
  logic       o_busy  [2];
  logic       o_load  [2];
  logic       o_en    [2];
  logic       o_done  [2];
  logic       o_err   [2];
  logic [4:0] o_ctr   [2];
  logic [4:0] o_rounds[2];

  assign o_ready[0] = bus0.ready;    assign o_ready[1] = bus1.ready;
  assign o_busy[0]  = bus0.busy;     assign o_busy[1]  = bus1.busy;
  assign o_load[0]  = bus0.load;     assign o_load[1]  = bus1.load;
  assign o_en[0]    = bus0.round_en; assign o_en[1]    = bus1.round_en;
  assign o_done[0]  = bus0.done;     assign o_done[1]  = bus1.done;
  assign o_err[0]   = bus0.err;      assign o_err[1]   = bus1.err;
  assign o_ctr[0]   = bus0.ctr;      assign o_ctr[1]   = bus1.ctr;
  assign o_rounds[0] = bus0.rounds;  assign o_rounds[1] = bus1.rounds;

  int compared = 0;
  int failed   = 0;

  // Reference model: a permutation is described by its accept edge and round count
  int unroll_m [2] = '{1, 2};
  bit active   [2];
  int acc      [2];
  int rr       [2];
  bit bad      [2];
  int idle_ctr [2];
  int cur_rnd  [2];
  int e = 0;

  task automatic model_reset;
    for (int d = 0; d < 2; d++) begin
      active[d]   = 1'b0;
      idle_ctr[d] = 0;
      cur_rnd[d]  = 12;
    end
  endtask

  // Advance the model across one rising edge with the given inputs
  task automatic model_edge(input bit s, input int rin, input bit ab);
    bit eff_ab;
`ifdef PERM_ABORT_EN
    eff_ab = ab;
`else
    eff_ab = 1'b0;
`endif
    e++;
    for (int d = 0; d < 2; d++) begin
      bit was_idle;
      int jp;
      int n;
      was_idle = !active[d];
      if (active[d]) begin
        jp = e - 1 - acc[d];
        n  = rr[d] / unroll_m[d];
        if (eff_ab && jp <= n) begin
          active[d]   = 1'b0;
          idle_ctr[d] = (jp == 0) ? 1 : 1 + (jp - 1) * unroll_m[d];
        end else if (jp == n + 1) begin
          active[d]   = 1'b0;
          idle_ctr[d] = 1 + (n - 1) * unroll_m[d];
        end
      end
      if (was_idle && s) begin
        active[d]  = 1'b1;
        acc[d]     = e;
        bad[d]     = !(rin == 6 || rin == 8 || rin == 12);
        rr[d]      = bad[d] ? 12 : rin;
        cur_rnd[d] = rr[d];
      end
    end
  endtask

  task automatic chk(input string tag, input int d, input logic [4:0] obs, input logic [4:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, d, obs, exp_v);
    end
  endtask

  task automatic check_all;
    for (int d = 0; d < 2; d++) begin
      logic [4:0] x_ctr;
      logic [4:0] x_rnd;
      logic       x_ready, x_busy, x_load, x_en, x_done, x_err;
      int         j;
      int         n;
      x_ctr = 5'(idle_ctr[d]);
      x_rnd = 5'(cur_rnd[d]);
      x_ready = 1'b1; x_busy = 1'b0; x_load = 1'b0;
      x_en = 1'b0; x_done = 1'b0; x_err = 1'b0;
      if (active[d]) begin
        j = e - acc[d];
        n = rr[d] / unroll_m[d];
        x_ready = 1'b0;
        x_busy  = 1'b1;
        if (j == 0) begin
          x_load = 1'b1;
          x_ctr  = 5'd1;
          x_err  = bad[d];
        end else if (j <= n) begin
          x_en  = 1'b1;
          x_ctr = 5'(1 + (j - 1) * unroll_m[d]);
        end else begin
          x_done = 1'b1;
          x_ctr  = 5'(1 + (n - 1) * unroll_m[d]);
        end
      end
      chk("ready",    d, {4'd0, o_ready[d]}, {4'd0, x_ready});
      chk("busy",     d, {4'd0, o_busy[d]},  {4'd0, x_busy});
      chk("load",     d, {4'd0, o_load[d]},  {4'd0, x_load});
      chk("round_en", d, {4'd0, o_en[d]},    {4'd0, x_en});
      chk("done",     d, {4'd0, o_done[d]},  {4'd0, x_done});
      chk("err",      d, {4'd0, o_err[d]},   {4'd0, x_err});
      chk("ctr",      d, o_ctr[d],    x_ctr);
      chk("rounds",   d, o_rounds[d], x_rnd);
    end
  endtask

  // One clock: drive at negedge, model the edge, sample 1 time unit later
  task automatic step(input bit s, input logic [4:0] rin, input bit ab);
    start     = s;
    rounds_in = rin;
    abort_v   = ab;
    @(posedge clk);
    model_edge(s, int'(rin), ab);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'($urandom_range(0, 31)), 1'b0);
  endtask

  // Reset is asynchronous: outputs must be idle values without any edge
  task automatic do_reset;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit         s;
    bit         ab;
    logic [4:0] rin;
    rst       = 1'b1;
    start     = 1'b0;
    rounds_in = 5'd0;
    abort_v   = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle after reset
    idle(5);
    // 6-round request
    step(1'b1, 5'd6, 1'b0);
    idle(20);
    // start held high with 12 rounds: back-to-back runs
    for (int i = 0; i < 46; i++) step(1'b1, 5'd12, 1'b0);
    idle(20);
    // illegal round count runs as 12 with err
    step(1'b1, 5'd5, 1'b0);
    idle(16);
    // 8-round request
    step(1'b1, 5'd8, 1'b0);
    idle(14);
    // reset in the middle of a run at ctr=4
    step(1'b1, 5'd12, 1'b0);
    idle(4);
    chk("ctr_before_rst", 0, o_ctr[0], 5'd4);
    do_reset();
    idle(3);
`ifdef PERM_ABORT_EN
    // abort at ctr=4, then abort together with start in idle
    step(1'b1, 5'd12, 1'b0);
    idle(4);
    step(1'b0, 5'd0, 1'b1);
    idle(5);
    step(1'b1, 5'd6, 1'b1);
    idle(20);
`endif
    // randomized traffic, including rounds_in churn and occasional abort
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       rin = 5'd6;
        1:       rin = 5'd8;
        2:       rin = 5'd12;
        default: rin = 5'($urandom_range(0, 31));
      endcase
      ab = ($urandom_range(0, 15) == 0);
      step(s, rin, ab);
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
